// File: rtl/oh_fifo_rdstream.sv
// oh_fifo_rdstream: drains a FIFO read port into a valid/ready stream through a small skid buffer
//   clk, reset             read-domain clock, asynchronous active-high reset
//   fifo_empty, fifo_rd_en FIFO read handshake; fifo_dout is valid the cycle after fifo_rd_en
//   flush                  synchronous discard of buffered and in-flight data
//   out_valid/out_ready    downstream handshake, out_data is the oldest buffered word
//   xfer_count             accepted-word counter, wraps silently
module oh_fifo_rdstream #(
    parameter int DW  = 104,
    parameter int BUF = 2,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_dout,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] xfer_count
);
    localparam int PW  = BUF > 1 ? $clog2(BUF) : 1;
    localparam int CNW = $clog2(BUF + 1);
    localparam int NW  = CNW + 1;
    logic [CNW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  xfer_q, xfer_d;
    logic           infl_q, drop_q, drop_d;
    logic [DW-1:0]  mem_q [BUF];
    logic           pop, cap;
    logic [NW-1:0]  occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid  = cnt_q != '0;
    assign out_data   = mem_q[rptr_q];
    assign xfer_count = xfer_q;

    always_comb begin
        pop        = out_valid & out_ready;
        // occupancy seen by a new read: buffered + in flight, minus the word leaving now
        occ        = NW'(cnt_q) + NW'(infl_q) - NW'(pop);
        fifo_rd_en = ~reset & ~flush & ~fifo_empty & (occ < NW'(BUF));
        // a word arriving during a flush belongs to the discarded stream
        cap        = infl_q & ~drop_q & ~flush;
        cnt_d      = flush ? '0 : cnt_q + CNW'(cap) - CNW'(pop);
        wptr_d     = flush ? '0 : cap ? nxt(wptr_q) : wptr_q;
        rptr_d     = flush ? '0 : pop ? nxt(rptr_q) : rptr_q;
        drop_d     = flush & infl_q;
        xfer_d     = xfer_q + CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            infl_q <= 1'b0;
            drop_q <= 1'b0;
            xfer_q <= '0;
            for (int i = 0; i < BUF; i++) mem_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            infl_q <= fifo_rd_en;
            drop_q <= drop_d;
            xfer_q <= xfer_d;
            if (cap) mem_q[wptr_q] <= fifo_dout;
        end
    end
endmodule

// File: tb/tb_oh_fifo_rdstream.sv
// tb_oh_fifo_rdstream: directed tests of the FIFO read-stream drain against a behavioural FIFO
module tb_oh_fifo_rdstream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  xfer_count;
    int errors = 0;
    int checks = 0;
    logic [15:0] mem [64];
    int rp;
    int wp = 0;
    logic [15:0] got [256];
    int ng = 0;

    oh_fifo_rdstream #(.DW(16), .BUF(2), .CW(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rp == wp);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rp        <= 0;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rp[5:0]];
            rp        <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && ng < 256) begin
            got[ng] = out_data;
            ng++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] v);
        mem[wp[5:0]] = v;
        wp++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        wp = 0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        wp = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
        checks++; if (xfer_count !== 4'd0) begin errors++; $display("FAIL reset_xfer got %0d exp 0", xfer_count); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int base;
        do_reset();
        base = ng;
        tick();
        out_ready = 1'b1;
        push(16'h00A5);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL t1_rd_en got %b exp 1", fifo_rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_n got %b exp 0", out_valid); end
        tick(); #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t1_rd_en_n1 got %b exp 0", fifo_rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_n1 got %b exp 0", out_valid); end
        tick(); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_n2 got %b exp 1", out_valid); end
        checks++; if (out_data !== 16'h00A5) begin errors++; $display("FAIL t1_data got %h exp 00a5", out_data); end
        tick(); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_n3 got %b exp 0", out_valid); end
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL t1_xfer got %0d exp 1", xfer_count); end
        checks++; if (ng - base !== 1 || got[base] !== 16'h00A5) begin errors++; $display("FAIL t1_stream got n=%0d w=%h exp n=1 w=00a5", ng - base, got[base]); end
    endtask

    task automatic test_streaming();
        int base, nrd, first, last;
        do_reset();
        base = ng; nrd = 0; first = -1; last = -1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
        for (int c = 0; c < 16; c++) begin
            #1;
            if (fifo_rd_en) begin
                nrd++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        checks++; if (nrd !== 10) begin errors++; $display("FAIL t2_rd_count got %0d exp 10", nrd); end
        checks++; if (first !== 0 || last !== 9) begin errors++; $display("FAIL t2_rd_run got %0d..%0d exp 0..9", first, last); end
        checks++; if (ng - base !== 10) begin errors++; $display("FAIL t2_words got %0d exp 10", ng - base); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (got[base + i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL t2_word%0d got %h exp %h", i, got[base + i], 16'h0100 + 16'(i)); end
        end
        checks++; if (xfer_count !== 4'd10) begin errors++; $display("FAIL t2_xfer got %0d exp 10", xfer_count); end
    endtask

    task automatic test_backpressure();
        int base, nrd;
        do_reset();
        base = ng; nrd = 0;
        tick();
        for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fifo_rd_en) nrd++;
            if (c >= 3) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 16'h0200) begin errors++; $display("FAIL t3_hold%0d got v=%b d=%h exp v=1 d=0200", c, out_valid, out_data); end
            end
            tick();
        end
        checks++; if (nrd !== 2) begin errors++; $display("FAIL t3_rd_pulses got %0d exp 2", nrd); end
        out_ready = 1'b1;
        repeat (10) tick();
        checks++; if (ng - base !== 5) begin errors++; $display("FAIL t3_words got %0d exp 5", ng - base); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[base + i] !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL t3_word%0d got %h exp %h", i, got[base + i], 16'h0200 + 16'(i)); end
        end
        checks++; if (xfer_count !== 4'd5) begin errors++; $display("FAIL t3_xfer got %0d exp 5", xfer_count); end
    endtask

    task automatic test_flush();
        int base;
        do_reset();
        base = ng;
        tick();
        push(16'h0300);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL t4_rd_en got %b exp 1", fifo_rd_en); end
        tick();
        flush = 1'b1;
        push(16'h0301);
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t4_rd_flush got %b exp 0", fifo_rd_en); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_dropped got %b exp 0", out_valid); end
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL t4_rd_after got %b exp 1", fifo_rd_en); end
        tick(); tick(); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0301) begin errors++; $display("FAIL t4_next got v=%b d=%h exp v=1 d=0301", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (xfer_count !== 4'd1 || got[base] !== 16'h0301) begin errors++; $display("FAIL t4_xfer got n=%0d w=%h exp n=1 w=0301", xfer_count, got[base]); end
        tick();
        push(16'h0310);
        push(16'h0311);
        tick(); tick(); tick(); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0310) begin errors++; $display("FAIL t4_full got v=%b d=%h exp v=1 d=0310", out_valid, out_data); end
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_flush_clear got %b exp 0", out_valid); end
        checks++; if (xfer_count !== 4'd2 || got[base + 1] !== 16'h0310) begin errors++; $display("FAIL t4_flush_pop got n=%0d w=%h exp n=2 w=0310", xfer_count, got[base + 1]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) push(16'h0400 + 16'(i));
        tick(); tick(); tick();
        out_ready = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL t5_pre got rd=%b v=%b exp rd=1 v=1", fifo_rd_en, out_valid); end
        tick(); #1;
        checks++; if (fifo_rd_en !== 1'b1 || xfer_count !== 4'd1) begin errors++; $display("FAIL t5_mid got rd=%b n=%0d exp rd=1 n=1", fifo_rd_en, xfer_count); end
        #1;
        reset = 1'b1;
        wp = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t5_async got v=%b rd=%b exp v=0 rd=0", out_valid, fifo_rd_en); end
        checks++; if (xfer_count !== 4'd0 || out_data !== 16'h0) begin errors++; $display("FAIL t5_clear got n=%0d d=%h exp n=0 d=0000", xfer_count, out_data); end
        out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = ng;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(16'h0500 + 16'(i));
        repeat (22) tick();
        #1;
        checks++; if (xfer_count !== 4'd1) begin errors++; $display("FAIL t6_wrap got %0d exp 1", xfer_count); end
        checks++; if (ng - base !== 17 || got[base + 16] !== 16'h0510) begin errors++; $display("FAIL t6_words got n=%0d w=%h exp n=17 w=0510", ng - base, got[base + 16]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
